// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - micro-programmed control sequencer with two dispatch tables and stall gating
module micro_sequencer #(
    parameter int UPC_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Stall,
    output logic             IRWrite,
    output logic             AdrSrc,
    output logic             NextPC,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic             ALUOp,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             Illegal,
    output logic [UPC_W-1:0] uPC
);

    localparam logic [UPC_W-1:0] S_FETCH    = UPC_W'(0);
    localparam logic [UPC_W-1:0] S_DECODE   = UPC_W'(1);
    localparam logic [UPC_W-1:0] S_MEMADR   = UPC_W'(2);
    localparam logic [UPC_W-1:0] S_MEMREAD  = UPC_W'(3);
    localparam logic [UPC_W-1:0] S_MEMWB    = UPC_W'(4);
    localparam logic [UPC_W-1:0] S_MEMWRITE = UPC_W'(5);
    localparam logic [UPC_W-1:0] S_EXECUTER = UPC_W'(6);
    localparam logic [UPC_W-1:0] S_EXECUTEI = UPC_W'(7);
    localparam logic [UPC_W-1:0] S_ALUWB    = UPC_W'(8);
    localparam logic [UPC_W-1:0] S_BRANCH   = UPC_W'(9);
    localparam logic [UPC_W-1:0] S_ILLEGAL  = UPC_W'(15);

    logic [UPC_W-1:0] upc_q;
    logic [UPC_W-1:0] upc_d;

    // Only Funct[5] (immediate) and Funct[0] (load) steer dispatch.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    // Micro-PC register; reset overrides stall and dispatch.
    always_ff @(posedge clk) begin
        if (reset) begin
            upc_q <= S_FETCH;
        end else begin
            upc_q <= upc_d;
        end
    end

    // Successor selection; a stall simply holds the current micro-address.
    always_comb begin
        upc_d = upc_q;
        if (!Stall) begin
            case (upc_q)
                S_FETCH:   upc_d = S_DECODE;
                S_DECODE: begin
                    case (Op)
                        2'b00:   upc_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                        2'b01:   upc_d = S_MEMADR;
                        2'b10:   upc_d = S_BRANCH;
                        default: upc_d = S_ILLEGAL;
                    endcase
                end
                S_MEMADR:  upc_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD: upc_d = S_MEMWB;
                S_EXECUTER,
                S_EXECUTEI: upc_d = S_ALUWB;
                S_ILLEGAL: upc_d = S_ILLEGAL;
                // MEMWB, MEMWRITE, ALUWB, BRANCH and unused addresses return to fetch
                default:   upc_d = S_FETCH;
            endcase
        end
    end

    // Moore decode of the micro-PC, with write strobes suppressed while stalled.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        Illegal   = 1'b0;
        case (upc_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB   = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc    = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                MemW      = 1'b1;
            end
            S_EXECUTER: begin
                ALUOp     = 1'b1;
            end
            S_EXECUTEI: begin
                ALUSrcB   = 2'b01;
                ALUOp     = 1'b1;
            end
            S_ALUWB: begin
                RegW      = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            S_ILLEGAL: begin
                Illegal   = 1'b1;
            end
            default: begin
                Illegal   = 1'b0;
            end
        endcase
        if (Stall) begin
            IRWrite = 1'b0;
            NextPC  = 1'b0;
            RegW    = 1'b0;
            MemW    = 1'b0;
        end
    end

    assign uPC = upc_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - directed self-checking bench for micro_sequencer
module tb_micro_sequencer;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       Stall;
    logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] uPC;

    micro_sequencer #(.UPC_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .Stall     (Stall),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .ALUOp     (ALUOp),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .Illegal   (Illegal),
        .uPC       (uPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, ALUSrcA, ALUSrcB, ResultSrc, Illegal}
    logic [13:0] dut_out;
    assign dut_out = {IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp,
                      ALUSrcA, ALUSrcB, ResultSrc, Illegal};

    localparam logic [13:0] STALL_MASK = 14'b01000111111111;

    int total = 0;
    int bad   = 0;
    int exp_upc;
    logic        lit_en = 1'b0;
    logic [13:0] lit_val;
    string       lit_name;

    // Output table per micro-address, written straight from the control table.
    function automatic logic [13:0] exp_out(input int a);
        case (a)
            0:       return 14'b1_0_1_0_0_0_0_01_10_10_0;
            1:       return 14'b0_0_0_0_0_0_0_01_10_10_0;
            2:       return 14'b0_0_0_0_0_0_0_00_01_00_0;
            3:       return 14'b0_1_0_0_0_0_0_00_00_00_0;
            4:       return 14'b0_0_0_1_0_0_0_00_00_01_0;
            5:       return 14'b0_1_0_0_1_0_0_00_00_00_0;
            6:       return 14'b0_0_0_0_0_0_1_00_00_00_0;
            7:       return 14'b0_0_0_0_0_0_1_00_01_00_0;
            8:       return 14'b0_0_0_1_0_0_0_00_00_00_0;
            9:       return 14'b0_0_0_0_0_1_0_00_01_10_0;
            15:      return 14'b0_0_0_0_0_0_0_00_00_00_1;
            default: return 14'b0;
        endcase
    endfunction

    task automatic check_cycle();
        logic [13:0] e;
        e = exp_out(exp_upc);
        if (Stall) e = e & STALL_MASK;
        total++;
        if (uPC !== 4'(exp_upc)) begin
            bad++;
            $display("FAIL upc t=%0t got=%0d want=%0d", $time, uPC, exp_upc);
        end
        total++;
        if (dut_out !== e) begin
            bad++;
            $display("FAIL outputs t=%0t upc=%0d got=%b want=%b", $time, exp_upc, dut_out, e);
        end
        if (lit_en) begin
            total++;
            if (dut_out !== lit_val) begin
                bad++;
                $display("FAIL %s got=%b want=%b", lit_name, dut_out, lit_val);
            end
        end
    endtask

    // One clock: apply inputs, check at the falling edge, advance past the rising edge.
    task automatic cyc(input logic [1:0] op, input logic [5:0] f, input logic st, input int eu);
        Op = op;
        Funct = f;
        Stall = st;
        exp_upc = eu;
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    // Whole instruction: 0 load, 1 store, 2 dp-reg, 3 dp-imm, 4 branch.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input int kind,
                             input int stall_idx, input int stall_n);
        int path[5];
        int len;
        path = '{0, 1, 0, 0, 0};
        case (kind)
            0:       begin path = '{0, 1, 2, 3, 4}; len = 5; end
            1:       begin path = '{0, 1, 2, 5, 0}; len = 4; end
            2:       begin path = '{0, 1, 6, 8, 0}; len = 4; end
            3:       begin path = '{0, 1, 7, 8, 0}; len = 4; end
            default: begin path = '{0, 1, 9, 0, 0}; len = 3; end
        endcase
        for (int i = 0; i < len; i++) begin
            if (i == stall_idx) begin
                for (int s = 0; s < stall_n; s++) cyc(op, f, 1'b1, path[i]);
            end
            cyc(op, f, 1'b0, path[i]);
        end
    endtask

    initial begin
        reset = 1'b1;
        Op = 2'b00;
        Funct = 6'b0;
        Stall = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // post-reset state shows FETCH values
        lit_en = 1'b1; lit_val = 14'b10100000110100; lit_name = "reset_fetch";
        Stall = 1'b0;
        exp_upc = 0;
        @(negedge clk);
        check_cycle();
        lit_en = 1'b0;
        // nothing advanced yet: hold the first fetch with a stall through the edge
        Stall = 1'b1;
        @(posedge clk);
        #1;

        // basic instruction classes
        run_instr(2'b01, 6'b000001, 0, -1, 0);
        run_instr(2'b01, 6'b000000, 1, -1, 0);
        run_instr(2'b00, 6'b100000, 3, -1, 0);
        run_instr(2'b10, 6'b000000, 4, -1, 0);
        run_instr(2'b00, 6'b000000, 2, -1, 0);
        run_instr(2'b00, 6'b011111, 2, -1, 0);
        run_instr(2'b01, 6'b111110, 1, -1, 0);
        run_instr(2'b01, 6'b100001, 0, -1, 0);

        // store with the MEMWRITE outputs pinned by hand
        cyc(2'b01, 6'b0, 1'b0, 0);
        cyc(2'b01, 6'b0, 1'b0, 1);
        cyc(2'b01, 6'b0, 1'b0, 2);
        lit_en = 1'b1; lit_val = 14'b01001000000000; lit_name = "memwrite";
        cyc(2'b01, 6'b0, 1'b0, 5);
        lit_en = 1'b0;

        // three-cycle stall in FETCH, first stalled cycle pinned by hand
        lit_en = 1'b1; lit_val = 14'b00000000110100; lit_name = "stalled_fetch";
        cyc(2'b01, 6'b000001, 1'b1, 0);
        lit_en = 1'b0;
        cyc(2'b01, 6'b000001, 1'b1, 0);
        cyc(2'b01, 6'b000001, 1'b1, 0);
        run_instr(2'b01, 6'b000001, 0, -1, 0);

        // stalls at write-back and memory-write suppress the strobes
        run_instr(2'b01, 6'b000001, 0, 4, 2);
        run_instr(2'b01, 6'b000000, 1, 3, 1);
        run_instr(2'b00, 6'b000000, 2, 3, 2);
        run_instr(2'b10, 6'b000000, 4, 2, 1);

        // dispatch inputs sampled only on the edge that leaves DECODE / MEMADR
        cyc(2'b11, 6'b0, 1'b0, 0);
        cyc(2'b11, 6'b0, 1'b1, 1);
        cyc(2'b11, 6'b1, 1'b1, 1);
        cyc(2'b01, 6'b1, 1'b0, 1);
        cyc(2'b11, 6'b1, 1'b1, 2);
        cyc(2'b11, 6'b0, 1'b0, 2);
        cyc(2'b11, 6'b0, 1'b0, 5);

        // reset at DECODE beats the illegal dispatch
        cyc(2'b11, 6'b0, 1'b0, 0);
        reset = 1'b1;
        cyc(2'b11, 6'b0, 1'b0, 1);
        reset = 1'b0;
        run_instr(2'b00, 6'b100000, 3, -1, 0);

        // reset at MEMWB while stalled: no RegW pulse, straight back to FETCH
        cyc(2'b01, 6'b000001, 1'b0, 0);
        cyc(2'b01, 6'b000001, 1'b0, 1);
        cyc(2'b01, 6'b000001, 1'b0, 2);
        cyc(2'b01, 6'b000001, 1'b0, 3);
        reset = 1'b1;
        cyc(2'b01, 6'b000001, 1'b1, 4);
        reset = 1'b0;
        cyc(2'b01, 6'b000000, 1'b0, 0);
        cyc(2'b01, 6'b000000, 1'b0, 1);
        cyc(2'b01, 6'b000000, 1'b0, 2);
        cyc(2'b01, 6'b000000, 1'b0, 5);

        // illegal opcode traps until reset
        cyc(2'b11, 6'b0, 1'b0, 0);
        cyc(2'b11, 6'b0, 1'b0, 1);
        for (int i = 0; i < 12; i++) begin
            if (i == 10) begin
                lit_en = 1'b1; lit_val = 14'b00000000000001; lit_name = "illegal_trap";
            end
            cyc(2'(i), 6'($urandom_range(0, 63)), (i % 3) == 0, 15);
            lit_en = 1'b0;
        end
        reset = 1'b1;
        cyc(2'b00, 6'b0, 1'b1, 15);
        reset = 1'b0;
        lit_en = 1'b1; lit_val = 14'b10100000110100; lit_name = "fetch_after_trap";
        cyc(2'b10, 6'b0, 1'b0, 0);
        lit_en = 1'b0;
        cyc(2'b10, 6'b0, 1'b0, 1);
        cyc(2'b10, 6'b0, 1'b0, 9);
        run_instr(2'b01, 6'b000001, 0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
